// File: rtl/io_map_pkg.sv
// io_map_pkg: register indices and base addresses shared by the address
// decode stage and the LED/switch IO responder, plus the debouncer state type.
package io_map_pkg;

    // Register indices (ALU address bits [3:1])
    localparam logic [2:0] LED_LO  = 3'd0;
    localparam logic [2:0] LED_HI  = 3'd1;
    localparam logic [2:0] SW_LO   = 3'd0;
    localparam logic [2:0] SW_HI   = 3'd1;
    localparam logic [2:0] SW_STAT = 3'd2;

    // Chip-select base addresses, consumed by the decode stage
    localparam logic [31:0] LED_BASE_ADDR = 32'hFFFF_FC60;
    localparam logic [31:0] SW_BASE_ADDR  = 32'hFFFF_FC70;

    typedef enum logic {
        DB_IDLE  = 1'b0,
        DB_COUNT = 1'b1
    } db_state_t;

endpackage

// File: rtl/switch_debouncer.sv
// switch_debouncer: 2-flop synchronizer followed by a whole-vector debounce.
// A new switch vector is accepted once it has been seen unchanged for
// DEBOUNCE_CYCLES consecutive cycles.
//   clock, reset : clock, synchronous active-high reset
//   sw_raw       : asynchronous switch pins
//   sw_stable    : last accepted (debounced) switch vector
//   commit       : high in the cycle whose edge loads sw_stable
module switch_debouncer
    import io_map_pkg::*;
#(
    parameter int WIDTH           = 24,
    parameter int DEBOUNCE_CYCLES = 2000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic             commit
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] sw_meta;
    logic [WIDTH-1:0] sw_sync;
    logic [WIDTH-1:0] sw_target, target_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    db_state_t        state, state_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            sw_meta   <= '0;
            sw_sync   <= '0;
            sw_target <= '0;
            sw_stable <= '0;
            cnt       <= '0;
            state     <= DB_IDLE;
        end else begin
            sw_meta   <= sw_raw;
            sw_sync   <= sw_meta;
            sw_target <= target_nxt;
            cnt       <= cnt_nxt;
            state     <= state_nxt;
            if (commit)
                sw_stable <= sw_sync;
        end
    end

    // The cycle in which a new value is first seen counts as its first stable
    // cycle, so a (re)started count is loaded with 1 and the value commits on
    // the edge where cnt == DEBOUNCE_CYCLES-1.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        target_nxt = sw_target;
        commit     = 1'b0;
        case (state)
            DB_IDLE: begin
                cnt_nxt = '0;
                if (sw_sync != sw_stable) begin
                    state_nxt  = DB_COUNT;
                    target_nxt = sw_sync;
                    cnt_nxt    = CNT_ONE;
                end
            end
            DB_COUNT: begin
                if (sw_sync == sw_stable) begin
                    state_nxt = DB_IDLE;
                    cnt_nxt   = '0;
                end else if (sw_sync != sw_target) begin
                    target_nxt = sw_sync;
                    cnt_nxt    = CNT_ONE;
                end else if (cnt == CNT_LAST) begin
                    commit    = 1'b1;
                    state_nxt = DB_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = DB_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/switch_led_io.sv
// switch_led_io: IO responder for the LED and switch chip selects.
// Holds the 24-bit LED register, debounces the board switches and returns
// switch/status data with one-cycle read latency.
//   clock, reset        : clock, synchronous active-high reset
//   ioRead, ioWrite     : IO strobes from the controller
//   LEDCtrl, SwitchCtrl : chip selects from address decode
//   addr                : register index (ALU address [3:1])
//   write_data          : low 16 bits of CPU write data
//   switch_in           : raw switch pins
//   io_rdata            : registered read data (zero when no read)
//   led_out             : registered LED pins
module switch_led_io
    import io_map_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ioRead,
    input  logic        ioWrite,
    input  logic        LEDCtrl,
    input  logic        SwitchCtrl,
    input  logic [2:0]  addr,
    input  logic [15:0] write_data,
    input  logic [23:0] switch_in,
    output logic [15:0] io_rdata,
    output logic [23:0] led_out
);

    logic [23:0] sw_stable;
    logic        commit;
    logic        sw_changed;
    logic        led_wr;
    logic        sw_rd;
    logic [15:0] rd_mux;

    assign led_wr = ioWrite & LEDCtrl;
    assign sw_rd  = ioRead & SwitchCtrl;

    switch_debouncer #(
        .WIDTH          (24),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clock    (clock),
        .reset    (reset),
        .sw_raw   (switch_in),
        .sw_stable(sw_stable),
        .commit   (commit)
    );

    always_comb begin
        rd_mux = '0;
        if (sw_rd) begin
            case (addr)
                SW_LO:   rd_mux = sw_stable[15:0];
                SW_HI:   rd_mux = {8'h00, sw_stable[23:16]};
                SW_STAT: rd_mux = {15'h0, sw_changed};
                default: rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            io_rdata   <= '0;
            led_out    <= '0;
            sw_changed <= 1'b0;
        end else begin
            io_rdata <= rd_mux;
            if (led_wr) begin
                case (addr)
                    LED_LO:  led_out[15:0]  <= write_data;
                    LED_HI:  led_out[23:16] <= write_data[7:0];
                    default: ;
                endcase
            end
            // A commit in the same cycle as a status read beats the clear;
            // the read itself still returns the pre-edge flag via rd_mux.
            if (commit)
                sw_changed <= 1'b1;
            else if (sw_rd && addr == SW_STAT)
                sw_changed <= 1'b0;
        end
    end

endmodule

// File: tb/tb_switch_led_io.sv
module tb_switch_led_io;

    localparam int N = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ioRead = 1'b0;
    logic        ioWrite = 1'b0;
    logic        LEDCtrl = 1'b0;
    logic        SwitchCtrl = 1'b0;
    logic [2:0]  addr = '0;
    logic [15:0] write_data = '0;
    logic [23:0] switch_in = '0;
    logic [15:0] io_rdata;
    logic [23:0] led_out;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    switch_led_io #(.DEBOUNCE_CYCLES(N)) dut (
        .clock     (clock),
        .reset     (reset),
        .ioRead    (ioRead),
        .ioWrite   (ioWrite),
        .LEDCtrl   (LEDCtrl),
        .SwitchCtrl(SwitchCtrl),
        .addr      (addr),
        .write_data(write_data),
        .switch_in (switch_in),
        .io_rdata  (io_rdata),
        .led_out   (led_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    // Debounce rule: a value of the synchronized switches that has persisted
    // for N consecutive edges and differs from the accepted value becomes
    // the accepted value. Synchronizer modelled as a 2-deep delay.
    typedef struct packed {
        logic [15:0] rd;
        logic [23:0] led;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] m_s1, m_sync, m_stable, m_run_val, m_led;
    int          m_run_len;
    logic        m_flag;

    always @(posedge clock) begin
        logic [15:0] rd_now;
        logic        cm;
        rd_now = '0;
        cm     = 1'b0;
        if (reset) begin
            m_s1 = '0; m_sync = '0; m_stable = '0; m_run_val = '0;
            m_run_len = 0; m_flag = 1'b0; m_led = '0;
        end else begin
            if (ioRead && SwitchCtrl) begin
                if (addr == 3'd0)      rd_now = m_stable[15:0];
                else if (addr == 3'd1) rd_now = {8'h00, m_stable[23:16]};
                else if (addr == 3'd2) rd_now = {15'h0, m_flag};
            end
            if (ioWrite && LEDCtrl) begin
                if (addr == 3'd0)      m_led[15:0]  = write_data;
                else if (addr == 3'd1) m_led[23:16] = write_data[7:0];
            end
            if (m_sync == m_run_val) m_run_len++;
            else begin
                m_run_val = m_sync;
                m_run_len = 1;
            end
            if (m_run_val != m_stable && m_run_len >= N) begin
                m_stable = m_run_val;
                cm = 1'b1;
            end
            if (ioRead && SwitchCtrl && addr == 3'd2) m_flag = 1'b0;
            if (cm) m_flag = 1'b1;
            m_sync = m_s1;
            m_s1   = switch_in;
        end
        exp_q.push_back('{rd: rd_now, led: m_led});
    end

    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("mon_rdata", 32'(io_rdata), 32'(e.rd));
            chk("mon_led", 32'(led_out), 32'(e.led));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_rd(input logic [2:0] a, output logic [15:0] v);
        ioRead = 1'b1; SwitchCtrl = 1'b1; ioWrite = 1'b0; LEDCtrl = 1'b0; addr = a;
        @(negedge clock);
        v = io_rdata;
        ioRead = 1'b0; SwitchCtrl = 1'b0;
    endtask

    task automatic do_wr(input logic [2:0] a, input logic [15:0] d);
        ioWrite = 1'b1; LEDCtrl = 1'b1; ioRead = 1'b0; SwitchCtrl = 1'b0;
        addr = a; write_data = d;
        @(negedge clock);
        ioWrite = 1'b0; LEDCtrl = 1'b0;
    endtask

    initial begin
        logic [15:0] v;
        logic [23:0] led_before;
        int          op;

        // Reset with switches held high
        switch_in = 24'hFFFFFF;
        repeat (3) tick();
        chk("rst_led", 32'(led_out), 32'h0);
        chk("rst_rdata", 32'(io_rdata), 32'h0);
        reset = 1'b0;
        repeat (5) tick();
        do_rd(3'd2, v); chk("rst_flag_coincide", 32'(v), 32'h0);
        do_rd(3'd2, v); chk("rst_flag_set", 32'(v), 32'h1);
        do_rd(3'd2, v); chk("rst_flag_cleared", 32'(v), 32'h0);
        do_rd(3'd0, v); chk("rst_sw_lo", 32'(v), 32'hFFFF);
        do_rd(3'd1, v); chk("rst_sw_hi", 32'(v), 32'h00FF);

        // LED writes
        do_wr(3'd0, 16'hA5C3);
        do_wr(3'd1, 16'h007E);
        chk("led_write", 32'(led_out), 32'h7EA5C3);
        do_wr(3'd3, 16'hFFFF);
        chk("led_addr3_ignored", 32'(led_out), 32'h7EA5C3);
        ioWrite = 1'b1; SwitchCtrl = 1'b1; addr = 3'd0; write_data = 16'h1234;
        tick();
        ioWrite = 1'b0; SwitchCtrl = 1'b0;
        chk("led_wr_swsel_noop", 32'(led_out), 32'h7EA5C3);
        ioRead = 1'b1; LEDCtrl = 1'b1; addr = 3'd0;
        tick();
        ioRead = 1'b0; LEDCtrl = 1'b0;
        chk("rd_ledsel_noop", 32'(io_rdata), 32'h0);

        // Switch read
        switch_in = 24'h12ABCD;
        repeat (7) tick();
        do_rd(3'd0, v); chk("sw_rd_lo", 32'(v), 32'hABCD);
        do_rd(3'd1, v); chk("sw_rd_hi", 32'(v), 32'h0012);
        tick();
        chk("rd_idle_zero", 32'(io_rdata), 32'h0);
        do_rd(3'd2, v); chk("stat_first", 32'(v), 32'h1);
        do_rd(3'd2, v); chk("stat_second", 32'(v), 32'h0);

        // Bounce rejection: stable bit 0 is made 0 first, then bit 0 bounces
        switch_in = 24'h12ABCC;
        repeat (8) tick();
        do_rd(3'd2, v); chk("pre_bounce_commit", 32'(v), 32'h1);
        for (int i = 0; i < 10; i++) begin
            switch_in[0] = (i % 2 == 0);
            repeat (2) tick();
        end
        do_rd(3'd2, v); chk("bounce_no_commit", 32'(v), 32'h0);
        switch_in[0] = 1'b1;
        repeat (4) tick();
        do_rd(3'd2, v); chk("bounce_edge5", 32'(v), 32'h0);
        do_rd(3'd2, v); chk("bounce_edge6_coincide", 32'(v), 32'h0);
        do_rd(3'd2, v); chk("bounce_committed", 32'(v), 32'h1);
        do_rd(3'd0, v); chk("bounce_value", 32'(v), 32'hABCD);

        // Reset mid-count
        switch_in = 24'h3C5A5A;
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (4) tick();
        do_rd(3'd0, v); chk("midrst_stable0_a", 32'(v), 32'h0);
        do_rd(3'd0, v); chk("midrst_stable0_b", 32'(v), 32'h0);
        do_rd(3'd0, v); chk("midrst_restart", 32'(v), 32'h5A5A);
        do_rd(3'd1, v); chk("midrst_hi", 32'(v), 32'h003C);
        chk("midrst_led", 32'(led_out), 32'h0);

        // Randomized traffic checked by the scoreboard
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                if ($urandom_range(0, 1) == 0) switch_in = 24'($urandom);
                else switch_in[$urandom_range(0, 23)] = ~switch_in[0];
            end
            op = int'($urandom_range(0, 4));
            ioRead = 1'b0; ioWrite = 1'b0; LEDCtrl = 1'b0; SwitchCtrl = 1'b0;
            addr = 3'($urandom_range(0, 7));
            write_data = 16'($urandom);
            case (op)
                1: begin ioRead = 1'b1;  SwitchCtrl = 1'b1; end
                2: begin ioWrite = 1'b1; LEDCtrl = 1'b1; end
                3: begin ioRead = 1'b1;  LEDCtrl = 1'b1; end
                4: begin ioWrite = 1'b1; SwitchCtrl = 1'b1; end
                default: ;
            endcase
            tick();
        end
        ioRead = 1'b0; ioWrite = 1'b0; LEDCtrl = 1'b0; SwitchCtrl = 1'b0;
        led_before = led_out;
        repeat (3) tick();
        chk("final_led_hold", 32'(led_out), 32'(led_before));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
